// File: rtl/pll_rst_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for a stable lock,
// then releases downstream domain resets one by one; retries and faults on timeout.
module pll_rst_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int N_DOMAINS     = 2,
    parameter int STAGGER       = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_lock,
    input  logic                 restart,
    output logic                 pll_rst,
    output logic [N_DOMAINS-1:0] dom_rst,
    output logic                 ready,
    output logic                 fault,
    output logic [3:0]           retry_cnt
);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max_int(max_int(RST_CYCLES, LOCK_TIMEOUT),
                                     max_int(STABLE_CYCLES, N_DOMAINS * STAGGER));
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_PRST  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_STAB  = 3'd2,
        ST_REL   = 3'd3,
        ST_RUN   = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        cnt_nxt_s;
    logic [3:0]           retry_nxt_s;
    logic                 lock_meta_r;
    logic                 lock_sync_r;
    logic                 pll_rst_nxt_s;
    logic [N_DOMAINS-1:0] dom_nxt_s;
    logic                 ready_nxt_s;
    logic                 fault_nxt_s;

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Next-state, counter and retry bookkeeping; restart overrides everything
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        retry_nxt_s = retry_cnt;
        if (restart) begin
            state_nxt_s = ST_PRST;
            cnt_nxt_s   = '0;
            retry_nxt_s = 4'd0;
        end else begin
            case (state_r)
                ST_PRST: begin
                    if (cnt_r == CW'(RST_CYCLES - 1)) begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (lock_sync_r) begin
                        state_nxt_s = ST_STAB;
                        cnt_nxt_s   = '0;
                    end else if (cnt_r == CW'(LOCK_TIMEOUT - 1)) begin
                        cnt_nxt_s = '0;
                        if (retry_cnt == 4'(MAX_RETRY)) begin
                            state_nxt_s = ST_FAULT;
                        end else begin
                            state_nxt_s = ST_PRST;
                            retry_nxt_s = retry_cnt + 4'd1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end
                ST_STAB: begin
                    if (!lock_sync_r) begin
                        // A glitch restarts the stability window without costing a retry
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = '0;
                    end else if (cnt_r == CW'(STABLE_CYCLES - 1)) begin
                        state_nxt_s = ST_REL;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end
                ST_REL: begin
                    if (!lock_sync_r) begin
                        state_nxt_s = ST_PRST;
                        cnt_nxt_s   = '0;
                    end else if (cnt_r == CW'((N_DOMAINS - 1) * STAGGER)) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = '0;
                        retry_nxt_s = 4'd0;
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end
                ST_RUN: begin
                    cnt_nxt_s = '0;
                    if (!lock_sync_r) begin
                        state_nxt_s = ST_PRST;
                    end else begin
                        retry_nxt_s = 4'd0;
                    end
                end
                ST_FAULT: begin
                    state_nxt_s = ST_FAULT;
                    cnt_nxt_s   = '0;
                end
                default: begin
                    state_nxt_s = ST_PRST;
                    cnt_nxt_s   = '0;
                    retry_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // Output values derived from the upcoming state so every output is a flop
    always_comb begin
        pll_rst_nxt_s = (state_nxt_s == ST_PRST) || (state_nxt_s == ST_FAULT);
        ready_nxt_s   = (state_nxt_s == ST_RUN);
        fault_nxt_s   = (state_nxt_s == ST_FAULT);
        dom_nxt_s     = {N_DOMAINS{1'b1}};
        for (int i = 0; i < N_DOMAINS; i++) begin
            // Domain i releases the cycle after REL's count has reached i*STAGGER
            if (state_nxt_s == ST_RUN) begin
                dom_nxt_s[i] = 1'b0;
            end else if ((state_nxt_s == ST_REL) && (cnt_nxt_s > CW'(i * STAGGER))) begin
                dom_nxt_s[i] = 1'b0;
            end else begin
                dom_nxt_s[i] = 1'b1;
            end
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_PRST;
            cnt_r     <= '0;
            pll_rst   <= 1'b1;
            dom_rst   <= {N_DOMAINS{1'b1}};
            ready     <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= 4'd0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pll_rst   <= pll_rst_nxt_s;
            dom_rst   <= dom_nxt_s;
            ready     <= ready_nxt_s;
            fault     <= fault_nxt_s;
            retry_cnt <= retry_nxt_s;
        end
    end

endmodule

// File: doc/pll_rst_sequencer.md
Name: pll_rst_sequencer

Overview:
- Controls the board PLL (50 MHz in) from the free-running input clock domain: drives its reset, monitors its lock, and releases downstream clock-domain resets only after lock is stable.
- Retries the PLL on lock timeout and flags a fault after repeated failures.
- Re-sequences automatically on loss of lock.
- Sits between the board clock/reset pins and every PLL-clocked subsystem (UDP, audio FFT/FIR, HDMI).

Parameters:
- RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
- LOCK_TIMEOUT, 50000, cycles allowed in WAIT for lock before retry (>=2)
- STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release (>=1)
- N_DOMAINS, 2, number of downstream reset outputs (1..8)
- STAGGER, 8, cycles between successive domain reset releases (>=1)
- MAX_RETRY, 3, retries after the first attempt before fault (0..15)

Ports:
- clk  in  1  free-running input clock, same source as the PLL's clkin1
- rst  in  1  synchronous, active-high reset
- pll_lock  in  1  PLL lock, asynchronous to clk
- restart  in  1  single-cycle request to re-sequence from scratch
- pll_rst  out  1  active-high reset to the PLL
- dom_rst  out  N_DOMAINS  active-high downstream resets; bit i released i-th
- ready  out  1  all domains released, lock good
- fault  out  1  retries exhausted
- retry_cnt  out  4  retries consumed in the current sequence

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- pll_lock passes through a 2-FF synchronizer (lock_s) before any use.
- While rst is high: state=PRST, cnt=0, pll_rst=1, dom_rst=all 1, ready=0, fault=0, retry_cnt=0.
- PRST: pll_rst=1. pll_rst is high for exactly RST_CYCLES cycles following rst deassertion or PRST entry, then go to WAIT with cnt=0.
- WAIT: pll_rst=0.
  - lock_s=1: go to STAB, cnt=0.
  - Otherwise, when cnt reaches LOCK_TIMEOUT-1:
    - retry_cnt==MAX_RETRY: go to FAULT.
    - else: retry_cnt+1 and go to PRST.
- STAB:
  - lock_s=0: return to WAIT with cnt=0. No retry is consumed.
  - STABLE_CYCLES consecutive lock_s=1 cycles: go to REL, cnt=0.
- REL: dom_rst[i] deasserts at cnt==i*STAGGER, on the cycle after that count is reached. After dom_rst[N_DOMAINS-1] deasserts, go to RUN.
- RUN: ready=1, retry_cnt cleared to 0.
- Lock loss in REL or RUN (lock_s=0):
  - Next cycle: dom_rst=all 1, ready=0, state=PRST.
  - retry_cnt is not incremented (a lost lock is not a failed attempt).
- FAULT: pll_rst=1, dom_rst=all 1, fault=1, ready=0. Held until restart or rst; pll_lock is ignored.
- restart=1 in any state: next cycle state=PRST, cnt=0, retry_cnt=0, fault=0, dom_rst=all 1, ready=0. Restart takes priority over every other transition in the same cycle.
- dom_rst bits never deassert out of order.
- dom_rst is all 1 whenever state is not REL or RUN.
- pll_rst and ready are never both 1.
- cnt is wide enough for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, N_DOMAINS*STAGGER). It is reset on every state change and never wraps.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, N_DOMAINS=2, STAGGER=4, MAX_RETRY=2):
- Nominal bring-up: rst high 3 cycles, release, pll_lock=1 from cycle 10.
  - pll_rst high exactly 4 cycles.
  - dom_rst[0] falls before dom_rst[1]; dom_rst[1] falls exactly 4 cycles after dom_rst[0].
  - ready=1 after dom_rst[1] falls; retry_cnt=0; fault=0.
- Lock never asserts:
  - pll_rst pulses 3 times (4 cycles each), 32-cycle WAIT gaps between pulses.
  - retry_cnt steps 0->1->2.
  - Then fault=1, pll_rst=1 and dom_rst=2'b11 held for 200 further cycles.
- Lock glitch during STAB: lock high 5 cycles, low 1, then high.
  - No retry consumed; STABLE count restarts.
  - ready is delayed accordingly; retry_cnt stays 0.
- Lock loss in RUN: drop pll_lock for 1 cycle.
  - 3 cycles later dom_rst=2'b11, ready=0, pll_rst high 4 cycles.
  - Full re-release follows; retry_cnt stays 0.
- Restart from FAULT, plus restart coincident with lock loss in RUN:
  - fault clears next cycle and a new PRST begins with retry_cnt=0.
  - The coincident case yields a single PRST entry.
- Reset mid-REL: assert rst when dom_rst=2'b10 -> next cycle dom_rst=2'b11, ready=0, pll_rst=1, state PRST.
